// File: rtl/id_ex_stage_if.sv
// rtl/id_ex_stage_if.sv - ID/EX stage bus: decode-side inputs and registered EX-side outputs
interface id_ex_stage_if #(
    parameter int DATA_W = 32
) ();
    logic              id_valid;
    logic [13:0]       id_ctrl;
    logic [DATA_W-1:0] id_pc4;
    logic [DATA_W-1:0] id_rs_data;
    logic [DATA_W-1:0] id_rt_data;
    logic [DATA_W-1:0] id_imm;
    logic [4:0]        id_rs;
    logic [4:0]        id_rt;
    logic [4:0]        id_rd;
    logic [5:0]        id_funct;
    logic              flush;
    logic              ex_hold;
    logic              id_stall;
    logic              ex_valid;
    logic [13:0]       ex_ctrl;
    logic [DATA_W-1:0] ex_pc4;
    logic [DATA_W-1:0] ex_rs_data;
    logic [DATA_W-1:0] ex_rt_data;
    logic [DATA_W-1:0] ex_imm;
    logic [4:0]        ex_rs;
    logic [4:0]        ex_rt;
    logic [4:0]        ex_dest;
    logic [5:0]        ex_funct;

    modport master (
        output id_valid, id_ctrl, id_pc4, id_rs_data, id_rt_data, id_imm,
               id_rs, id_rt, id_rd, id_funct, flush, ex_hold,
        input  id_stall, ex_valid, ex_ctrl, ex_pc4, ex_rs_data, ex_rt_data,
               ex_imm, ex_rs, ex_rt, ex_dest, ex_funct
    );

    modport slave (
        input  id_valid, id_ctrl, id_pc4, id_rs_data, id_rt_data, id_imm,
               id_rs, id_rt, id_rd, id_funct, flush, ex_hold,
        output id_stall, ex_valid, ex_ctrl, ex_pc4, ex_rs_data, ex_rt_data,
               ex_imm, ex_rs, ex_rt, ex_dest, ex_funct
    );
endinterface

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with load-use bubble insertion and bubble counter
module id_ex_stage #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    id_ex_stage_if.slave     bus,
    output logic [CNT_W-1:0] bubble_cnt
);
    // id_ctrl bit positions
    localparam int C_REGDST  = 0;
    localparam int C_ALUSRC  = 1;
    localparam int C_MEMREAD = 5;
    localparam int C_MEMWR   = 6;
    localparam int C_BRANCH  = 7;
    localparam int C_BRANCHN = 8;
    localparam int C_JAL     = 11;

    logic              valid_q;
    logic [13:0]       ctrl_q;
    logic [DATA_W-1:0] pc4_q;
    logic [DATA_W-1:0] rs_data_q;
    logic [DATA_W-1:0] rt_data_q;
    logic [DATA_W-1:0] imm_q;
    logic [4:0]        rs_q;
    logic [4:0]        rt_q;
    logic [4:0]        dest_q;
    logic [5:0]        funct_q;
    logic [CNT_W-1:0]  cnt_q;

    logic uses_rt;
    logic lu;

    // Hazard when the load in EX writes a register the ID instruction actually reads
    always_comb begin
        uses_rt = !bus.id_ctrl[C_ALUSRC] | bus.id_ctrl[C_MEMWR]
                | bus.id_ctrl[C_BRANCH] | bus.id_ctrl[C_BRANCHN];
        lu = valid_q & ctrl_q[C_MEMREAD] & (rt_q != 5'd0) & bus.id_valid
           & ((rt_q == bus.id_rs) | ((rt_q == bus.id_rt) & uses_rt));
    end

    assign bus.id_stall   = bus.ex_hold | (lu & !bus.flush);
    assign bus.ex_valid   = valid_q;
    assign bus.ex_ctrl    = ctrl_q;
    assign bus.ex_pc4     = pc4_q;
    assign bus.ex_rs_data = rs_data_q;
    assign bus.ex_rt_data = rt_data_q;
    assign bus.ex_imm     = imm_q;
    assign bus.ex_rs      = rs_q;
    assign bus.ex_rt      = rt_q;
    assign bus.ex_dest    = dest_q;
    assign bus.ex_funct   = funct_q;
    assign bubble_cnt     = cnt_q;

    // EX register update: reset, flush, hold, bubble, then normal load
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q   <= 1'b0;
            ctrl_q    <= '0;
            pc4_q     <= '0;
            rs_data_q <= '0;
            rt_data_q <= '0;
            imm_q     <= '0;
            rs_q      <= '0;
            rt_q      <= '0;
            dest_q    <= '0;
            funct_q   <= '0;
            cnt_q     <= '0;
        end else if (bus.flush) begin
            valid_q <= 1'b0;
            ctrl_q  <= '0;
        end else if (bus.ex_hold) begin
            valid_q <= valid_q;
        end else if (lu) begin
            valid_q <= 1'b0;
            ctrl_q  <= '0;
            if (cnt_q != {CNT_W{1'b1}}) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end else begin
            valid_q   <= bus.id_valid;
            ctrl_q    <= bus.id_valid ? bus.id_ctrl : 14'd0;
            pc4_q     <= bus.id_pc4;
            rs_data_q <= bus.id_rs_data;
            rt_data_q <= bus.id_rt_data;
            imm_q     <= bus.id_imm;
            rs_q      <= bus.id_rs;
            rt_q      <= bus.id_rt;
            funct_q   <= bus.id_funct;
            dest_q    <= bus.id_ctrl[C_JAL]    ? 5'd31 :
                         bus.id_ctrl[C_REGDST] ? bus.id_rd : bus.id_rt;
        end
    end
endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - self-checking bench for id_ex_stage
module tb_id_ex_stage;
    localparam int DATA_W = 32;
    localparam int CNT_W  = 2;
    localparam int CMAX   = (1 << CNT_W) - 1;

    localparam logic [13:0] ADD  = 14'b10_0000_0000_1001;
    localparam logic [13:0] LW   = 14'b00_0000_0010_1110;
    localparam logic [13:0] ADDI = 14'b00_0000_0000_1010;
    localparam logic [13:0] JAL  = 14'b00_1000_0000_1000;

    logic             clk;
    logic             rst_n;
    logic [CNT_W-1:0] bubble_cnt;

    id_ex_stage_if #(.DATA_W(DATA_W)) bus ();

    id_ex_stage #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .bubble_cnt (bubble_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    typedef struct {
        bit          rst;
        bit          vld;
        logic [13:0] ctrl;
        logic [4:0]  rs, rt, rd;
        bit          flush, hold;
        bit          chk_stall, e_stall;
        bit          e_valid;
        logic [13:0] e_ctrl;
        logic [4:0]  e_dest;
        int          e_src;
        int          e_cnt;
    } vec_t;

    vec_t vq[$];

    function automatic void add(bit rst, bit vld, logic [13:0] ctrl, logic [4:0] rs, logic [4:0] rt,
                                logic [4:0] rd, bit flush, bit hold, bit cs, bit es, bit ev,
                                logic [13:0] ec, logic [4:0] ed, int src, int ecnt);
        vec_t v;
        v.rst = rst; v.vld = vld; v.ctrl = ctrl; v.rs = rs; v.rt = rt; v.rd = rd;
        v.flush = flush; v.hold = hold; v.chk_stall = cs; v.e_stall = es;
        v.e_valid = ev; v.e_ctrl = ec; v.e_dest = ed;
        v.e_src = (src == -2) ? vq.size() : src;
        v.e_cnt = ecnt;
        vq.push_back(v);
    endfunction

    function automatic logic [31:0] pc_of(int i);
        return 32'h1000 + 32'(i) * 4;
    endfunction

    // reference model of the EX slot
    bit          m_valid;
    logic [13:0] m_ctrl;
    logic [31:0] m_pc4, m_rsd, m_rtd, m_imm;
    logic [4:0]  m_rs, m_rt, m_dest;
    logic [5:0]  m_funct;
    int          m_cnt;

    function automatic bit reads_rt(logic [13:0] c);
        return (c[1] == 1'b0) || c[6] || c[7] || c[8];
    endfunction

    initial begin
        bit exp_lu, exp_stall;
        int c, c2;
        rst_n = 1'b0;
        bus.id_valid = 0; bus.id_ctrl = 0; bus.id_pc4 = 0; bus.id_rs_data = 0;
        bus.id_rt_data = 0; bus.id_imm = 0; bus.id_rs = 0; bus.id_rt = 0;
        bus.id_rd = 0; bus.id_funct = 0; bus.flush = 0; bus.ex_hold = 0;

        // directed table
        add(0,1,ADD, 1,2,3, 0,0, 0,0, 0,0,   0,-1, 0);
        add(0,1,ADD, 1,2,3, 0,0, 1,0, 0,0,   0,-1, 0);
        add(1,1,ADD, 1,3,5, 0,0, 1,0, 1,ADD, 5,-2, 0);
        add(1,1,LW,  1,2,0, 0,0, 1,0, 1,LW,  2,-2, 0);
        add(1,1,ADD, 2,3,6, 0,0, 1,1, 0,0,   0,-1, 1);
        add(1,1,ADD, 2,3,6, 0,0, 1,0, 1,ADD, 6,-2, 1);
        add(1,1,LW,  1,0,0, 0,0, 1,0, 1,LW,  0,-2, 1);
        add(1,1,ADD, 0,0,7, 0,0, 1,0, 1,ADD, 7,-2, 1);
        add(1,1,LW,  1,4,0, 0,0, 1,0, 1,LW,  4,-2, 1);
        add(1,1,ADDI,1,4,0, 0,0, 1,0, 1,ADDI,4,-2, 1);
        add(1,1,LW,  1,2,0, 0,0, 1,0, 1,LW,  2,-2, 1);
        add(1,1,ADD, 2,3,6, 1,1, 1,1, 0,0,   0,-1, 1);
        add(1,1,ADD, 1,3,5, 0,0, 1,0, 1,ADD, 5,-2, 1);
        for (int k = 0; k < 3; k++)
            add(1,1,JAL, 0,9,0, 0,1, 1,1, 1,ADD, 5,12, 1);
        add(1,1,JAL, 0,7,0, 0,0, 1,0, 1,JAL,31,-2, 1);
        add(1,0,ADD, 1,3,5, 0,0, 1,0, 0,0,   0,-1, 1);
        c = 1;
        for (int k = 0; k < 4; k++) begin
            c2 = (c + 1 > CMAX) ? CMAX : c + 1;
            add(1,1,LW,  1,2,0, 0,0, 1,0, 1,LW,  2,-2, c);
            add(1,1,ADD, 2,3,6, 0,0, 1,1, 0,0,   0,-1, c2);
            add(1,1,ADD, 2,3,6, 0,0, 1,0, 1,ADD, 6,-2, c2);
            c = c2;
        end
        add(1,1,LW,  1,2,0, 0,0, 1,0, 1,LW,  2,-2, CMAX);
        add(0,1,ADD, 2,3,6, 0,0, 1,1, 0,0,   0,-1, 0);
        add(1,1,ADD, 2,3,6, 0,0, 1,0, 1,ADD, 6,-2, 0);

        @(posedge clk); #1;
        for (int i = 0; i < vq.size(); i++) begin
            rst_n = vq[i].rst;
            bus.id_valid = vq[i].vld; bus.id_ctrl = vq[i].ctrl;
            bus.id_rs = vq[i].rs; bus.id_rt = vq[i].rt; bus.id_rd = vq[i].rd;
            bus.flush = vq[i].flush; bus.ex_hold = vq[i].hold;
            bus.id_pc4 = pc_of(i); bus.id_rs_data = $urandom; bus.id_rt_data = $urandom;
            bus.id_imm = $urandom; bus.id_funct = 6'($urandom);
            #1;
            if (vq[i].chk_stall) chk($sformatf("t%0d stall", i), 64'(bus.id_stall), 64'(vq[i].e_stall));
            @(posedge clk); #1;
            chk($sformatf("t%0d valid", i), 64'(bus.ex_valid), 64'(vq[i].e_valid));
            chk($sformatf("t%0d ctrl", i), 64'(bus.ex_ctrl), 64'(vq[i].e_ctrl));
            chk($sformatf("t%0d cnt", i), 64'(bubble_cnt), 64'(vq[i].e_cnt));
            if (vq[i].e_valid) begin
                chk($sformatf("t%0d dest", i), 64'(bus.ex_dest), 64'(vq[i].e_dest));
                chk($sformatf("t%0d pc4", i), 64'(bus.ex_pc4), 64'(pc_of(vq[i].e_src)));
            end
            if (!vq[i].rst)
                chk($sformatf("t%0d rstdata", i),
                    64'({bus.ex_pc4, bus.ex_rs_data} | {bus.ex_rt_data, bus.ex_imm}
                        | 64'({bus.ex_rs, bus.ex_rt, bus.ex_dest, bus.ex_funct})), 64'd0);
        end

        // randomized run against the model; first cycle forces reset to sync the model
        for (int i = 0; i < 400; i++) begin
            rst_n = (i == 0) ? 1'b0 : ($urandom_range(0, 49) != 0);
            bus.id_valid = ($urandom_range(0, 7) != 0);
            bus.id_ctrl = 14'($urandom);
            bus.id_ctrl[5] = $urandom_range(0, 1);
            bus.id_rs = 5'($urandom_range(0, 3));
            bus.id_rt = 5'($urandom_range(0, 3));
            bus.id_rd = 5'($urandom);
            bus.id_funct = 6'($urandom);
            bus.id_pc4 = $urandom; bus.id_rs_data = $urandom;
            bus.id_rt_data = $urandom; bus.id_imm = $urandom;
            bus.flush = ($urandom_range(0, 7) == 0);
            bus.ex_hold = ($urandom_range(0, 5) == 0);
            #1;
            exp_lu = m_valid && m_ctrl[5] && m_rt != 0 && bus.id_valid &&
                     (m_rt == bus.id_rs || (m_rt == bus.id_rt && reads_rt(bus.id_ctrl)));
            exp_stall = bus.ex_hold || (exp_lu && !bus.flush);
            if (i != 0) chk($sformatf("r%0d stall", i), 64'(bus.id_stall), 64'(exp_stall));
            if (!rst_n) begin
                m_valid = 0; m_ctrl = 0; m_pc4 = 0; m_rsd = 0; m_rtd = 0; m_imm = 0;
                m_rs = 0; m_rt = 0; m_dest = 0; m_funct = 0; m_cnt = 0;
            end else if (bus.flush) begin
                m_valid = 0; m_ctrl = 0;
            end else if (bus.ex_hold) begin
                m_valid = m_valid;
            end else if (exp_lu) begin
                m_valid = 0; m_ctrl = 0;
                m_cnt = (m_cnt < CMAX) ? m_cnt + 1 : CMAX;
            end else begin
                m_valid = bus.id_valid;
                m_ctrl = bus.id_valid ? bus.id_ctrl : 14'd0;
                m_pc4 = bus.id_pc4; m_rsd = bus.id_rs_data; m_rtd = bus.id_rt_data;
                m_imm = bus.id_imm; m_rs = bus.id_rs; m_rt = bus.id_rt; m_funct = bus.id_funct;
                m_dest = bus.id_ctrl[11] ? 5'd31 : (bus.id_ctrl[0] ? bus.id_rd : bus.id_rt);
            end
            @(posedge clk); #1;
            chk($sformatf("r%0d valid", i), 64'(bus.ex_valid), 64'(m_valid));
            chk($sformatf("r%0d ctrl", i), 64'(bus.ex_ctrl), 64'(m_ctrl));
            chk($sformatf("r%0d cnt", i), 64'(bubble_cnt), 64'(m_cnt));
            if (m_valid) begin
                chk($sformatf("r%0d ops", i), {bus.ex_rs_data, bus.ex_rt_data}, {m_rsd, m_rtd});
                chk($sformatf("r%0d pc_imm", i), {bus.ex_pc4, bus.ex_imm}, {m_pc4, m_imm});
                chk($sformatf("r%0d regs", i),
                    64'({bus.ex_rs, bus.ex_rt, bus.ex_dest, bus.ex_funct}),
                    64'({m_rs, m_rt, m_dest, m_funct}));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
